// File: rtl/turtle_trace_buffer.sv
// rtl/turtle_trace_buffer.sv - execution trace capture buffer beside turtle_cpu_core
//
// Records one entry per retired instruction into a circular buffer, stops on a
// PC breakpoint after a post-trigger window, and drains oldest-first.
//
// Ports:
//   clk, reset_n          core clock, asynchronous active-low reset
//   retire_valid, pc, instruction, acc, status, branch_taken
//                         retiring instruction snapshot
//   arm                   pulse: clear buffer and start capture
//   mode                  0 = fill until full, 1 = circular until trigger
//   bp_pc, bp_en          breakpoint addresses and per-breakpoint enables
//   halt_en               allow halt_req on trigger
//   post_count            entries captured after the trigger entry
//   rd_en                 pop oldest entry (IDLE/DONE only)
//   rd_data, rd_valid     popped entry {pc, instruction, acc, status, branch_taken}
//   entry_count           entries held
//   trig_index            trigger entry position counted from the oldest
//   triggered, halt_req   trigger flag and one-cycle halt request
//   state                 IDLE=0, ARMED=1, POST=2, DONE=3

module turtle_trace_buffer #(
    parameter int PC_WIDTH     = 10,
    parameter int INSTR_WIDTH  = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STATUS_WIDTH = 4,
    parameter int DEPTH        = 64,
    parameter int NUM_BP       = 2
) (
    input  logic                                                       clk,
    input  logic                                                       reset_n,
    input  logic                                                       retire_valid,
    input  logic [PC_WIDTH-1:0]                                        pc,
    input  logic [INSTR_WIDTH-1:0]                                     instruction,
    input  logic [DATA_WIDTH-1:0]                                      acc,
    input  logic [STATUS_WIDTH-1:0]                                    status,
    input  logic                                                       branch_taken,
    input  logic                                                       arm,
    input  logic                                                       mode,
    input  logic [NUM_BP*PC_WIDTH-1:0]                                 bp_pc,
    input  logic [NUM_BP-1:0]                                          bp_en,
    input  logic                                                       halt_en,
    input  logic [$clog2(DEPTH)-1:0]                                   post_count,
    input  logic                                                       rd_en,
    output logic [PC_WIDTH+INSTR_WIDTH+DATA_WIDTH+STATUS_WIDTH:0]      rd_data,
    output logic                                                       rd_valid,
    output logic [$clog2(DEPTH):0]                                     entry_count,
    output logic [$clog2(DEPTH)-1:0]                                   trig_index,
    output logic                                                       triggered,
    output logic                                                       halt_req,
    output logic [1:0]                                                 state
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = PC_WIDTH + INSTR_WIDTH + DATA_WIDTH + STATUS_WIDTH + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [EW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic [AW-1:0]  r_trig_index;
    logic [AW-1:0]  r_remaining;
    logic           r_triggered;
    logic           r_halt_req;
    logic [EW-1:0]  r_rd_data;
    logic           r_rd_valid;

    logic           w_bp_hit;
    logic           w_capture;
    logic           w_full;
    logic           w_trigger;
    logic           w_rd_accept;
    logic [AW:0]    w_new_count;
    logic [EW-1:0]  w_wr_entry;

    always_comb begin
        w_bp_hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (pc == bp_pc[i*PC_WIDTH +: PC_WIDTH])) begin
                w_bp_hit = 1'b1;
            end
        end
    end

    // arm takes priority: the retire seen in the arm cycle is dropped.
    assign w_capture   = retire_valid && !arm &&
                         ((r_state == S_ARMED) || (r_state == S_POST));
    assign w_full      = (r_count == CNT_FULL);
    // A full buffer only receives a write when circular, so the write overwrites.
    assign w_new_count = w_full ? r_count : (r_count + CNT_ONE);
    assign w_trigger   = w_capture && (r_state == S_ARMED) && !r_triggered && w_bp_hit;
    assign w_rd_accept = rd_en && !arm && (r_count != '0) &&
                         ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_wr_entry  = {pc, instruction, acc, status, branch_taken};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (arm) begin
            w_state_nxt = S_ARMED;
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (w_capture) begin
                        if (!mode) begin
                            // Fill mode: breakpoints never end the capture.
                            if (w_new_count == CNT_FULL) begin
                                w_state_nxt = S_DONE;
                            end
                        end else if (w_trigger) begin
                            w_state_nxt = (post_count == '0) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (w_capture && (r_remaining <= PTR_ONE)) begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Trace storage: synchronous write, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Pointers, counters, trigger bookkeeping and registered read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_trig_index <= '0;
            r_remaining  <= '0;
            r_triggered  <= 1'b0;
            r_halt_req   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_halt_req <= w_trigger && halt_en;
            r_rd_valid <= w_rd_accept;

            if (arm) begin
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_count      <= '0;
                r_trig_index <= '0;
                r_remaining  <= '0;
                r_triggered  <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    r_count  <= w_new_count;
                    if (w_full) begin
                        r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    end

                    if (w_trigger) begin
                        r_triggered  <= 1'b1;
                        // Trigger entry is the newest one after this write.
                        r_trig_index <= w_full ? PTR_LAST : r_count[AW-1:0];
                        // post_count cannot exceed DEPTH-1 given its width.
                        r_remaining  <= post_count;
                    end else if (r_triggered && w_full && (r_trig_index != '0)) begin
                        // Overwrite dropped the oldest entry; trigger moves one closer.
                        r_trig_index <= r_trig_index - PTR_ONE;
                    end

                    if (r_state == S_POST) begin
                        r_remaining <= r_remaining - PTR_ONE;
                    end
                end

                if (w_rd_accept) begin
                    r_rd_data <= r_mem[r_rd_ptr];
                    r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                    r_count   <= r_count - CNT_ONE;
                end
            end
        end
    end

    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign entry_count = r_count;
    assign trig_index  = r_trig_index;
    assign triggered   = r_triggered;
    assign halt_req    = r_halt_req;
    assign state       = r_state;

endmodule

// File: tb/tb_turtle_trace_buffer.sv
// tb/tb_turtle_trace_buffer.sv - directed self-checking bench for turtle_trace_buffer

module tb_turtle_trace_buffer;

    localparam int PCW = 10;
    localparam int EW  = 39;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            retire_valid;
    logic [PCW-1:0]  pc;
    logic [15:0]     instruction;
    logic [7:0]      acc;
    logic [3:0]      status;
    logic            branch_taken;
    logic            arm;
    logic            mode;
    logic [2*PCW-1:0] bp_pc;
    logic [1:0]      bp_en;
    logic            halt_en;
    logic [2:0]      post_count;
    logic            rd_en;
    logic [EW-1:0]   rd_data;
    logic            rd_valid;
    logic [3:0]      entry_count;
    logic [2:0]      trig_index;
    logic            triggered;
    logic            halt_req;
    logic [1:0]      state;

    int n_checks = 0;
    int n_errors = 0;

    turtle_trace_buffer #(
        .PC_WIDTH(10), .INSTR_WIDTH(16), .DATA_WIDTH(8),
        .STATUS_WIDTH(4), .DEPTH(8), .NUM_BP(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .retire_valid(retire_valid), .pc(pc),
        .instruction(instruction), .acc(acc), .status(status),
        .branch_taken(branch_taken), .arm(arm), .mode(mode), .bp_pc(bp_pc),
        .bp_en(bp_en), .halt_en(halt_en), .post_count(post_count), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .entry_count(entry_count),
        .trig_index(trig_index), .triggered(triggered), .halt_req(halt_req),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] exp_entry(input logic [PCW-1:0] p);
        logic [15:0] ins;
        ins = 16'hA000 | {6'd0, p};
        return {p, ins, p[7:0], p[3:0], p[0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [PCW-1:0] p);
        logic [EW-1:0] e;
        e = exp_entry(p);
        retire_valid = 1'b1;
        {pc, instruction, acc, status, branch_taken} = e;
        tick();
        retire_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic exp_valid, input logic [PCW-1:0] p);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, rd_valid, exp_valid);
        if (exp_valid) check({tag, "_data"}, rd_data, exp_entry(p));
    endtask

    initial begin
        reset_n = 1'b0; retire_valid = 1'b0; pc = '0; instruction = '0; acc = '0;
        status = '0; branch_taken = 1'b0; arm = 1'b0; mode = 1'b0; bp_pc = '0;
        bp_en = '0; halt_en = 1'b0; post_count = '0; rd_en = 1'b0;
        tick(); tick();

        check("rst_state",     state, 2'd0);
        check("rst_count",     entry_count, 4'd0);
        check("rst_rd_valid",  rd_valid, 1'b0);
        check("rst_rd_data",   rd_data, '0);
        check("rst_trig_index", trig_index, 3'd0);
        check("rst_triggered", triggered, 1'b0);
        check("rst_halt_req",  halt_req, 1'b0);
        reset_n = 1'b1;
        tick();

        // FILL mode; bp1 at pc 3 enabled, bp0 at pc 1 disabled.
        mode = 1'b0; bp_pc = {10'd3, 10'd1}; bp_en = 2'b10; halt_en = 1'b0;
        do_arm();
        check("fill_armed_state", state, 2'd1);
        for (int i = 0; i < 10; i++) begin
            retire(10'(i));
            if (i == 1) check("fill_bp0_masked", triggered, 1'b0);
            if (i == 3) begin
                check("fill_trig", triggered, 1'b1);
                check("fill_trig_state", state, 2'd1);
                check("fill_trig_index", trig_index, 3'd3);
            end
            if (i == 6) check("fill_state_pre_full", state, 2'd1);
            if (i == 7) check("fill_done_state", state, 2'd3);
        end
        check("fill_count", entry_count, 4'd8);
        for (int i = 0; i < 8; i++) pop_expect($sformatf("fill_pop%0d", i), 1'b1, 10'(i));
        pop_expect("fill_pop_empty", 1'b0, 10'd0);
        check("fill_empty_count", entry_count, 4'd0);
        check("fill_empty_state", state, 2'd3);

        // CIRC with trigger at pc 20, post window 2, no halt.
        mode = 1'b1; bp_pc = {10'd0, 10'd20}; bp_en = 2'b01; post_count = 3'd2; halt_en = 1'b0;
        do_arm();
        check("circ_rearm_count", entry_count, 4'd0);
        for (int i = 10; i <= 30; i++) begin
            retire(10'(i));
            if (i == 19) check("circ_pre_trig", triggered, 1'b0);
            if (i == 20) begin
                check("circ_trig", triggered, 1'b1);
                check("circ_post_state", state, 2'd2);
                check("circ_no_halt", halt_req, 1'b0);
                check("circ_trig_idx_hit", trig_index, 3'd7);
            end
            if (i == 21) check("circ_still_post", state, 2'd2);
            if (i == 22) check("circ_done", state, 2'd3);
        end
        check("circ_count", entry_count, 4'd8);
        check("circ_trig_index", trig_index, 3'd5);
        for (int i = 15; i <= 22; i++) pop_expect($sformatf("circ_pop%0d", i), 1'b1, 10'(i));

        // Same with halt enabled; pc 20 recurs inside the post window.
        halt_en = 1'b1;
        do_arm();
        for (int i = 10; i <= 19; i++) retire(10'(i));
        check("halt_before", halt_req, 1'b0);
        retire(10'd20);
        check("halt_pulse", halt_req, 1'b1);
        retire(10'd21);
        check("halt_one_cycle", halt_req, 1'b0);
        retire(10'd20);
        check("halt_no_repeat", halt_req, 1'b0);
        check("halt_done", state, 2'd3);
        tick();
        check("halt_no_repeat2", halt_req, 1'b0);

        // arm and rd_en together in DONE: arm wins.
        arm = 1'b1; rd_en = 1'b1;
        tick();
        arm = 1'b0; rd_en = 1'b0;
        check("armrd_state", state, 2'd1);
        check("armrd_count", entry_count, 4'd0);
        check("armrd_valid", rd_valid, 1'b0);
        // rd_en while ARMED is ignored.
        bp_en = 2'b00;
        retire(10'd40); retire(10'd41);
        pop_expect("armed_pop", 1'b0, 10'd0);
        check("armed_pop_count", entry_count, 4'd2);

        // CIRC, post_count 0, trigger on 4th retire.
        bp_pc = {10'd0, 10'd5}; bp_en = 2'b01; post_count = 3'd0; halt_en = 1'b0;
        do_arm();
        retire(10'd1); retire(10'd2); retire(10'd3); retire(10'd5);
        check("p0_state", state, 2'd3);
        check("p0_count", entry_count, 4'd4);
        check("p0_trig_index", trig_index, 3'd3);
        pop_expect("p0_pop0", 1'b1, 10'd1);
        pop_expect("p0_pop1", 1'b1, 10'd2);
        pop_expect("p0_pop2", 1'b1, 10'd3);
        pop_expect("p0_pop3", 1'b1, 10'd5);

        // Asynchronous reset during POST.
        bp_pc = {10'd0, 10'd20}; post_count = 3'd2; halt_en = 1'b1;
        do_arm();
        retire(10'd18); retire(10'd19); retire(10'd20);
        check("rstpost_state_pre", state, 2'd2);
        check("rstpost_halt_pre", halt_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstpost_state", state, 2'd0);
        check("rstpost_count", entry_count, 4'd0);
        check("rstpost_triggered", triggered, 1'b0);
        check("rstpost_halt", halt_req, 1'b0);
        check("rstpost_trig_index", trig_index, 3'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
